cordic_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares the single 16-bit vectoring CORDIC between up to NUM_REQ requesters (roll, pitch, heading, calibration paths). It sits between the processing state machines in `tt_um_kalman` and the `cordic` instance. It does the following for the granted requester:
- latches that requester's operands;
- drives the CORDIC start pulse;
- waits for `done`, with a watchdog;
- returns the angle and magnitude to that requester only, with a one-cycle response pulse.

---
 rtl/cordic_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cordic_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin arbiter and sequencer sharing one vectoring CORDIC
// between NUM_REQ requesters.
//
// For the granted requester the block:
//   - latches that requester's operands;
//   - pulses cordic_start;
//   - waits for cordic_done, guarded by a watchdog;
//   - returns angle/magnitude to that requester with a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req[NUM_REQ]             per-requester request level
//   x_in, y_in               flattened signed operands, requester i at [i*DW +: DW]
//   ack[NUM_REQ]             one-hot, one cycle: request accepted, operands captured
//   rsp_valid[NUM_REQ]       one-hot, one cycle: result for that requester
//   rsp_angle, rsp_mag       result, held until the next response
//   rsp_err                  qualifies rsp_valid; 1 = watchdog timeout
//   busy                     high whenever not idle
//   grant_id                 index of current/last granted requester
//   cordic_start             one-cycle start to the CORDIC
//   cordic_x, cordic_y       registered operands to the CORDIC
//   cordic_angle, cordic_mag CORDIC results, valid with cordic_done
//   cordic_done              CORDIC completion pulse
module cordic_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*DW-1:0]  x_in,
  input  logic [NUM_REQ*DW-1:0]  y_in,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic signed [DW-1:0]   rsp_angle,
  output logic signed [DW-1:0]   rsp_mag,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   cordic_start,
  output logic signed [DW-1:0]   cordic_x,
  output logic signed [DW-1:0]   cordic_y,
  input  logic signed [DW-1:0]   cordic_angle,
  input  logic signed [DW-1:0]   cordic_mag,
  input  logic                   cordic_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]             r_state;
  logic [2:0]             r_last;
  logic [2:0]             r_gid;
  logic [7:0]             r_timer;
  logic [NUM_REQ-1:0]     r_ack;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic signed [DW-1:0]   r_rsp_angle;
  logic signed [DW-1:0]   r_rsp_mag;
  logic                   r_rsp_err;
  logic                   r_start;
  logic signed [DW-1:0]   r_cx;
  logic signed [DW-1:0]   r_cy;

  logic                   w_any;
  logic [2:0]             w_sel;
  logic [NUM_REQ-1:0]     w_sel_oh;
  logic [NUM_REQ-1:0]     w_cur_oh;
  logic signed [DW-1:0]   w_sel_x;
  logic signed [DW-1:0]   w_sel_y;

  // Round-robin pick: walk positions last+1 .. last+NUM_REQ (mod NUM_REQ).
  // Iterating from the farthest position down lets the nearest hit win.
  always_comb begin
    int unsigned idx;
    idx   = '0;
    w_sel = '0;
    w_any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 32'(r_last) + 32'(k) + 32'd1;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (idx == 32'(i) && req[i]) w_sel = 3'(i);
      end
    end
  end

  // Operand mux and one-hot decodes of the new and the in-flight grant.
  always_comb begin
    w_sel_x  = '0;
    w_sel_y  = '0;
    w_sel_oh = '0;
    w_cur_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == 3'(i)) begin
        w_sel_x     = x_in[i*DW +: DW];
        w_sel_y     = y_in[i*DW +: DW];
        w_sel_oh[i] = 1'b1;
      end
      if (r_gid == 3'(i)) w_cur_oh[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 3'(NUM_REQ - 1);
      r_gid       <= '0;
      r_timer     <= '0;
      r_ack       <= '0;
      r_rsp_valid <= '0;
      r_rsp_angle <= '0;
      r_rsp_mag   <= '0;
      r_rsp_err   <= 1'b0;
      r_start     <= 1'b0;
      r_cx        <= '0;
      r_cy        <= '0;
    end else begin
      // Pulses default low; each is set for exactly one cycle below.
      r_ack       <= '0;
      r_start     <= 1'b0;
      r_rsp_valid <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ack   <= w_sel_oh;
            r_start <= 1'b1;
            r_cx    <= w_sel_x;
            r_cy    <= w_sel_y;
            r_gid   <= w_sel;
            r_last  <= w_sel;
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done on the expiry edge takes priority over the watchdog.
          if (cordic_done) begin
            r_rsp_angle <= cordic_angle;
            r_rsp_mag   <= cordic_mag;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= w_cur_oh;
            r_state     <= ST_RESP;
          end else if (r_timer == 8'(TIMEOUT - 1)) begin
            r_rsp_angle <= '0;
            r_rsp_mag   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= w_cur_oh;
            r_state     <= ST_RESP;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_RESP: begin
          r_rsp_err <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack          = r_ack;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_angle    = r_rsp_angle;
  assign rsp_mag      = r_rsp_mag;
  assign rsp_err      = r_rsp_err;
  assign busy         = (r_state != ST_IDLE);
  assign grant_id     = r_gid;
  assign cordic_start = r_start;
  assign cordic_x     = r_cx;
  assign cordic_y     = r_cy;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Testbench for cordic_arbiter: a behavioural CORDIC stand-in, randomized
// requesters and a behavioural reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_cordic_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 63;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*DW-1:0] x_in = '0;
  logic [NUM_REQ*DW-1:0] y_in = '0;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_angle;
  logic [DW-1:0]         rsp_mag;
  logic                  rsp_err;
  logic                  busy;
  logic [2:0]            grant_id;
  logic                  cordic_start;
  logic [DW-1:0]         cordic_x;
  logic [DW-1:0]         cordic_y;
  logic [DW-1:0]         cordic_angle = '0;
  logic [DW-1:0]         cordic_mag = '0;
  logic                  cordic_done = 1'b0;

  cordic_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .x_in         (x_in),
    .y_in         (y_in),
    .ack          (ack),
    .rsp_valid    (rsp_valid),
    .rsp_angle    (rsp_angle),
    .rsp_mag      (rsp_mag),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .grant_id     (grant_id),
    .cordic_start (cordic_start),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_angle (cordic_angle),
    .cordic_mag   (cordic_mag),
    .cordic_done  (cordic_done)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     cmp_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- CORDIC stand-in ----------------
  int            cd_lat      = 5;    // 0 = never completes
  bit            cd_rand_lat = 1'b0;
  bit            cd_fixed    = 1'b0;
  bit            stray_en    = 1'b0;
  bit            cd_force    = 1'b0;
  logic [DW-1:0] cd_a        = '0;
  logic [DW-1:0] cd_m        = '0;
  int            cd_cnt      = 0;

  task automatic drive_done();
    cordic_done  = 1'b1;
    cordic_angle = cd_fixed ? cd_a : 16'($urandom);
    cordic_mag   = cd_fixed ? cd_m : 16'($urandom);
  endtask

  always @(negedge clk) begin
    cordic_done = 1'b0;
    if (cd_force || (stray_en && $urandom_range(0, 39) == 0)) begin
      cd_force = 1'b0;
      drive_done();
    end else if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0) drive_done();
    end
    if (cordic_start) begin
      if (cd_rand_lat) cd_cnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 25));
      else             cd_cnt = cd_lat;
    end
  end

  // ---------------- Reference model ----------------
  // One operation: grant, then wait up to TIMEOUT edges for done, then one
  // response cycle and one idle cycle before the next grant can happen.
  int               m_owner = -1;
  int               m_age   = 0;
  int               m_last  = NUM_REQ - 1;
  int               m_g;
  bit               m_cool  = 1'b0;
  logic [NUM_REQ-1:0] e_ack = '0, e_rv = '0;
  logic             e_start = 1'b0, e_err = 1'b0;
  logic [DW-1:0]    e_ang = '0, e_mag = '0, e_cx = '0, e_cy = '0;
  logic [2:0]       e_gid = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_age = 0; m_last = NUM_REQ - 1; m_cool = 1'b0;
      e_ack = '0; e_rv = '0; e_start = 1'b0; e_err = 1'b0;
      e_ang = '0; e_mag = '0; e_cx = '0; e_cy = '0; e_gid = '0;
    end else begin
      e_ack = '0; e_start = 1'b0; e_rv = '0; e_err = 1'b0;
      if (m_cool) begin
        m_cool = 1'b0;
      end else if (m_owner >= 0) begin
        m_age++;
        if (cordic_done || m_age == TIMEOUT) begin
          e_rv    = 4'(1 << m_owner);
          e_err   = !cordic_done;
          e_ang   = cordic_done ? cordic_angle : '0;
          e_mag   = cordic_done ? cordic_mag : '0;
          m_owner = -1;
          m_cool  = 1'b1;
        end
      end else if (req != '0) begin
        m_g = -1;
        for (int k = 1; k <= NUM_REQ; k++)
          if (m_g < 0 && req[(m_last + k) % NUM_REQ]) m_g = (m_last + k) % NUM_REQ;
        e_ack   = 4'(1 << m_g);
        e_start = 1'b1;
        e_cx    = x_in[m_g*DW +: DW];
        e_cy    = y_in[m_g*DW +: DW];
        e_gid   = 3'(m_g);
        m_last  = m_g;
        m_owner = m_g;
        m_age   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ack", 32'(ack), 32'(e_ack));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("rsp_angle", 32'(rsp_angle), 32'(e_ang));
      chk("rsp_mag", 32'(rsp_mag), 32'(e_mag));
      chk("busy", 32'(busy), 32'((m_owner >= 0) || m_cool));
      chk("grant_id", 32'(grant_id), 32'(e_gid));
      chk("cordic_start", 32'(cordic_start), 32'(e_start));
      chk("cordic_x", 32'(cordic_x), 32'(e_cx));
      chk("cordic_y", 32'(cordic_y), 32'(e_cy));
    end
  end

  // ---------------- Stimulus helpers ----------------
  // Requesters drop req during their ack cycle.
  task automatic tick();
    @(negedge clk);
    req = req & ~ack;
  endtask

  task automatic wait_ack(output longint c);
    bit ok = 1'b0;
    c = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      tick();
      if (ack != '0) begin ok = 1'b1; c = cyc; end
    end
    chk("ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(output longint c);
    bit ok = 1'b0;
    c = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      tick();
      if (rsp_valid != '0) begin ok = 1'b1; c = cyc; end
    end
    chk("rsp_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    req = '0;
    repeat (40) tick();
    #1 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  longint ca, cr, c2;
  int     cnt;
  int     gnt_q[$];
  int     exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Single request with fixed CORDIC result.
    cd_fixed = 1'b1; cd_a = 16'd0; cd_m = 16'd1647; cd_lat = 5;
    x_in[0 +: DW] = 16'd1000; y_in[0 +: DW] = 16'd0;
    req = 4'b0001;
    wait_ack(ca);
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_start", 32'(cordic_start), 32'd1);
    chk("t1_cx", 32'(cordic_x), 32'd1000);
    tick();
    chk("t1_ack_width", 32'(ack), 32'h0);
    chk("t1_start_width", 32'(cordic_start), 32'd0);
    wait_rsp(cr);
    chk("t1_rv", 32'(rsp_valid), 32'h1);
    chk("t1_angle", 32'(rsp_angle), 32'd0);
    chk("t1_mag", 32'(rsp_mag), 32'd1647);
    chk("t1_err", 32'(rsp_err), 32'd0);

    // Contention: 0 wins, 2 follows two edges after 0's response edge.
    do_reset();
    cd_lat = 4;
    req = 4'b0101;
    wait_ack(ca);
    chk("t2_first", 32'(ack), 32'h1);
    wait_rsp(cr);
    wait_ack(c2);
    chk("t2_second", 32'(ack), 32'h4);
    chk("t2_gap", 32'(c2 - cr), 32'd2);

    // Fairness under continuous full request.
    do_reset();
    cd_lat = 3;
    req = 4'hF;
    gnt_q.delete();
    for (int n = 0; n < 8; n++) begin
      wait_ack(ca);
      gnt_q.push_back(int'(grant_id));
      tick();
      req = 4'hF;
    end
    for (int n = 0; n < 8; n++) chk("t3_order", 32'(gnt_q[n]), 32'(exp_order[n]));

    // Timeout, then a stray done while idle.
    do_reset();
    cd_lat = 0;
    req = 4'b0001;
    wait_ack(ca);
    wait_rsp(cr);
    chk("t4_delay", 32'(cr - ca), 32'(TIMEOUT));
    chk("t4_err", 32'(rsp_err), 32'd1);
    chk("t4_angle", 32'(rsp_angle), 32'd0);
    chk("t4_mag", 32'(rsp_mag), 32'd0);
    tick();
    cd_force = 1'b1;
    cnt = 0;
    repeat (10) begin tick(); if (rsp_valid != '0) cnt++; end
    chk("t4_idle_done", 32'(cnt), 32'd0);

    // Withdrawn request while another is in flight.
    do_reset();
    cd_lat = 20;
    req = 4'b0001;
    wait_ack(ca);
    cnt = 0;
    tick();
    req[1] = 1'b1;
    repeat (3) begin tick(); if (ack[1]) cnt++; end
    req[1] = 1'b0;
    repeat (30) begin tick(); if (ack[1]) cnt++; end
    chk("t5_no_ack1", 32'(cnt), 32'd0);

    // Done on the watchdog expiry edge: done wins.
    do_reset();
    cd_lat = TIMEOUT - 1;
    req = 4'b0001;
    wait_ack(ca);
    wait_rsp(cr);
    chk("t6_delay", 32'(cr - ca), 32'(TIMEOUT));
    chk("t6_err", 32'(rsp_err), 32'd0);

    // Reset in the middle of WAIT.
    do_reset();
    cd_lat = 10;
    x_in[0 +: DW] = 16'd1000;
    req = 4'b0001;
    wait_ack(ca);
    repeat (5) tick();
    #1 rst = 1'b1;
    #1;
    chk("t7_ack", 32'(ack), 32'h0);
    chk("t7_rv", 32'(rsp_valid), 32'h0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_gid", 32'(grant_id), 32'd0);
    chk("t7_start", 32'(cordic_start), 32'd0);
    chk("t7_cx", 32'(cordic_x), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    cnt = 0;
    repeat (15) begin tick(); if (rsp_valid != '0) cnt++; end
    chk("t7_no_rsp", 32'(cnt), 32'd0);
    req = 4'b1000;
    wait_ack(ca);
    chk("t7_ack3", 32'(ack), 32'h8);
    chk("t7_gid3", 32'(grant_id), 32'd3);

    // Randomized traffic against the model.
    cd_fixed = 1'b0; cd_rand_lat = 1'b1; stray_en = 1'b1;
    repeat (4000) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && !ack[i] && $urandom_range(0, 3) == 0) begin
          x_in[i*DW +: DW] = 16'($urandom);
          y_in[i*DW +: DW] = 16'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 49) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    stray_en = 1'b0;
    repeat (100) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
